// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp : data-memory responder for the MEM stage.
//
// The responder takes one load or store per request/ready handshake, performs
// it on a word-organised RAM with byte-lane write enables, and returns a
// single-cycle response. The response carries formatted load data (sign- or
// zero-extended according to funct3) or an error flag. WAIT_CYCLES extra
// cycles can be inserted between accept and response to model slow memory.
//
// Optional build macro:
//   DMEM_B2B_EN - ready is also high in the response cycle, so a new request
//                 can be accepted while the previous response is presented.
//
// Parameters:
//   DEPTH_WORDS  memory size in 32-bit words (power of two)
//   WAIT_CYCLES  extra accept-to-response cycles, 0..15
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             synchronous reset, active-low
//   mem2ram_req_i     request valid, held with its fields until accepted
//   mem2ram_we_i      1 = store, 0 = load
//   mem2ram_addr_i    byte address
//   mem2ram_funct3_i  RISC-V load/store funct3
//   mem2ram_wdata_i   store data, right-aligned
//   ram2mem_ready_o   a request can be accepted this cycle
//   ram2mem_rvalid_o  response valid, one-cycle pulse
//   ram2mem_rdata_o   formatted load data, 0 for stores and errors
//   ram2mem_err_o     error for this response, qualified by rvalid
// -----------------------------------------------------------------------------
module dmem_resp #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem2ram_req_i,
  input  logic        mem2ram_we_i,
  input  logic [31:0] mem2ram_addr_i,
  input  logic [2:0]  mem2ram_funct3_i,
  input  logic [31:0] mem2ram_wdata_i,
  output logic        ram2mem_ready_o,
  output logic        ram2mem_rvalid_o,
  output logic [31:0] ram2mem_rdata_o,
  output logic        ram2mem_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

`ifdef DMEM_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wcnt_p0, wcnt_nxt;
  logic        accept;
  logic        mem_op;
  logic        mem_fire;

  logic        req_we_p0;
  logic [31:0] req_addr_p0;
  logic [2:0]  req_f3_p0;
  logic [31:0] req_wdata_p0;

  logic        op_we;
  logic [31:0] op_addr;
  logic [2:0]  op_f3;
  logic [31:0] op_wdata;
  logic [AW-1:0] op_idx;
  logic [1:0]  op_lane;
  logic        op_err;
  logic [3:0]  op_be;
  logic [31:0] op_wword;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_p1;
  logic        err_p1;

  // ---------------------------------------------------------------------------
  // Access checks and data formatting
  // ---------------------------------------------------------------------------
  function automatic logic access_err(input logic we, input logic [31:0] addr,
                                      input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    if (we) bad = (f3 > 3'b010);
    else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3[1:0] == 2'b01) && addr[0])          bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (addr[1:0] != 0)) bad = 1'b1;
    if ((addr >> (AW + 2)) != 32'd0)             bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data across lanes; the enables pick the lane.
  function automatic logic [31:0] store_word(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and FSM
  // ---------------------------------------------------------------------------
  // Gating with rst_n keeps ready low during the reset cycle itself.
  assign ram2mem_ready_o  = rst_n && ((state == S_IDLE) || (B2B && (state == S_RESP)));
  assign ram2mem_rvalid_o = (state == S_RESP);
  assign accept           = mem2ram_req_i & ram2mem_ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wcnt_p0 <= 4'd0;
    end else begin
      state   <= state_nxt;
      wcnt_p0 <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt_p0;
    mem_op    = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            wcnt_nxt  = 4'd0;
          end else begin
            state_nxt = S_RESP;
            mem_op    = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_p0 == WAIT_LAST) begin
          state_nxt = S_RESP;
          wcnt_nxt  = 4'd0;
          mem_op    = 1'b1;
        end else begin
          wcnt_nxt  = wcnt_p0 + 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A reset landing on the edge that would enter RESP must not write memory.
  assign mem_fire = mem_op & rst_n;

  // ---------------------------------------------------------------------------
  // Stage p0: request capture at accept
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we_p0    <= mem2ram_we_i;
      req_addr_p0  <= mem2ram_addr_i;
      req_f3_p0    <= mem2ram_funct3_i;
      req_wdata_p0 <= mem2ram_wdata_i;
    end
  end

  // With no wait cycles the operation happens on the accept edge itself, so
  // the live request fields are used; otherwise the captured copy is.
  always_comb begin
    if (state == S_WAIT) begin
      op_we    = req_we_p0;
      op_addr  = req_addr_p0;
      op_f3    = req_f3_p0;
      op_wdata = req_wdata_p0;
    end else begin
      op_we    = mem2ram_we_i;
      op_addr  = mem2ram_addr_i;
      op_f3    = mem2ram_funct3_i;
      op_wdata = mem2ram_wdata_i;
    end
  end

  assign op_idx   = op_addr[AW+1:2];
  assign op_lane  = op_addr[1:0];
  assign op_err   = access_err(op_we, op_addr, op_f3);
  assign op_be    = store_be(op_lane, op_f3);
  assign op_wword = store_word(op_wdata, op_f3);

  // ---------------------------------------------------------------------------
  // Stage p1: memory access and registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_fire && op_we && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else if (mem_fire) begin
      err_p1   <= op_err;
      rdata_p1 <= (op_err || op_we) ? 32'd0 : load_fmt(mem[op_idx], op_lane, op_f3);
    end
  end

  assign ram2mem_rdata_o = rdata_p1;
  assign ram2mem_err_o   = err_p1;

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp : self-checking bench for dmem_resp.
// Instance 0 runs with WAIT_CYCLES = 0, instance 1 with WAIT_CYCLES = 3.
// Expected responses come from a byte-addressed memory model that applies the
// load/store/error rules directly.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

  localparam int W1 = 3;
  localparam int MEM_BYTES = 4096 * 4;

`ifdef DMEM_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [2:0]  f3     [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  logic [7:0]  mdl [2][MEM_BYTES];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  dmem_resp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .mem2ram_req_i(req[0]), .mem2ram_we_i(we[0]), .mem2ram_addr_i(addr[0]),
    .mem2ram_funct3_i(f3[0]), .mem2ram_wdata_i(wdata[0]),
    .ram2mem_ready_o(ready[0]), .ram2mem_rvalid_o(rvalid[0]),
    .ram2mem_rdata_o(rdata[0]), .ram2mem_err_o(err[0])
  );

  dmem_resp #(.DEPTH_WORDS(4096), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .mem2ram_req_i(req[1]), .mem2ram_we_i(we[1]), .mem2ram_addr_i(addr[1]),
    .mem2ram_funct3_i(f3[1]), .mem2ram_wdata_i(wdata[1]),
    .ram2mem_ready_o(ready[1]), .ram2mem_rvalid_o(rvalid[1]),
    .ram2mem_rdata_o(rdata[1]), .ram2mem_err_o(err[1])
  );

  // Reference model: byte-addressed memory, access size from funct3[1:0].
  task automatic model(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int nb;
    logic [31:0] v;
    nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    if (w) e = (f > 3'd2);
    else   e = (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
    if (nb == 2 && a[0])          e = 1'b1;
    if (nb == 4 && a[1:0] != 2'd0) e = 1'b1;
    if (a >= 32'(MEM_BYTES))       e = 1'b1;
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[d][int'(a) + i];
        if (!f[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endtask

  // One complete transaction with latency, pulse and data checks.
  task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] wd, input string nm);
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          n;
    lat = (d == 0) ? 0 : W1;
    model(d, w, a, f, wd, er, ee);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; f3[d] = f; wdata[d] = wd;
    n = 0;
    while (!ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ready[d]) begin
      errors++;
      $display("FAIL %s ready-timeout dut%0d: ready=%b after %0d cycles, want 1", nm, d, ready[d], n);
    end
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
    for (int k = 0; k < lat; k++) begin
      checks++;
      if (rvalid[d] !== 1'b0 || ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s wait dut%0d cyc%0d: rvalid=%b ready=%b, want 0 0", nm, d, k, rvalid[d], ready[d]);
      end
      @(negedge clk);
    end
    checks++;
    if (rvalid[d] !== 1'b1 || ready[d] !== B2B) begin
      errors++;
      $display("FAIL %s resp dut%0d: rvalid=%b ready=%b, want 1 %b", nm, d, rvalid[d], ready[d], B2B);
    end
    checks++;
    if (rdata[d] !== er || err[d] !== ee) begin
      errors++;
      $display("FAIL %s data dut%0d: rdata=%h err=%b, want rdata=%h err=%b", nm, d, rdata[d], err[d], er, ee);
    end
    @(negedge clk);
    checks++;
    if (rvalid[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse dut%0d: rvalid=%b one cycle later, want 0", nm, d, rvalid[d]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'd0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: ready=%b rvalid=%b rdata=%h err=%b, want 0 0 0 0",
                 d, ready[d], rvalid[d], rdata[d], err[d]);
      end
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset-release dut%0d: ready=%b, want 1", d, ready[d]);
      end
    end
  endtask

  task automatic test_directed(input int d);
    do_req(d, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, "sw");
    do_req(d, 1'b0, 32'h10, 3'b010, 32'h0, "lw");
    do_req(d, 1'b0, 32'h13, 3'b000, 32'h0, "lb");
    do_req(d, 1'b0, 32'h13, 3'b100, 32'h0, "lbu");
    do_req(d, 1'b0, 32'h10, 3'b001, 32'h0, "lh");
    do_req(d, 1'b0, 32'h12, 3'b101, 32'h0, "lhu");
    do_req(d, 1'b1, 32'h11, 3'b000, 32'h12345677, "sb");
    do_req(d, 1'b0, 32'h10, 3'b010, 32'h0, "lw-after-sb");
    do_req(d, 1'b0, 32'h12, 3'b010, 32'h0, "lw-misalign");
    do_req(d, 1'b1, 32'h11, 3'b001, 32'hAAAA5555, "sh-misalign");
    do_req(d, 1'b0, 32'h10, 3'b010, 32'h0, "lw-unchanged");
    do_req(d, 1'b0, 32'h10, 3'b111, 32'h0, "ld-f3-111");
    do_req(d, 1'b1, 32'h10, 3'b011, 32'h0, "st-f3-011");
    do_req(d, 1'b0, 32'h4000, 3'b010, 32'h0, "lw-oor");
    do_req(d, 1'b1, 32'h12, 3'b001, 32'h0000CAFE, "sh");
    do_req(d, 1'b0, 32'h10, 3'b010, 32'h0, "lw-after-sh");
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    do_req(1, 1'b1, 32'h20, 3'b010, 32'h11111111, "sw-pre");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; f3[1] = 3'b010; wdata[1] = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    checks++;
    if (ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL midrst-wait: ready=%b, want 0", ready[1]);
    end
    rst_n[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rvalid[1] === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst-norvalid: %0d rvalid cycles, want 0", seen);
    end
    do_req(1, 1'b0, 32'h20, 3'b010, 32'h0, "lw-after-midrst");
  endtask

  task automatic test_random();
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    int          r;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 16; k++) do_req(d, 1'b1, 32'(k * 4), 3'b010, $urandom, "fill");
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 40; k++) begin
        w = 1'($urandom_range(0, 1));
        f = 3'($urandom_range(0, 7));
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'h4000 + 32'($urandom_range(0, 255));
        else if (r == 1) a = $urandom | 32'h0001_0000;
        else             a = 32'($urandom_range(0, 63));
        do_req(d, w, a, f, $urandom, "random");
      end
    end
  endtask

  task automatic test_back_to_back();
    int i, nresp, run, maxrun, cyc, sp, exp_run;
    int acc [4];
    logic rdy;
    logic [31:0] er;
    logic ee;
    i = 0; nresp = 0; run = 0; maxrun = 0; cyc = 0;
    for (int k = 0; k < 4; k++) acc[k] = 0;
    exp_q.delete();
    while ((i < 4 || nresp < 4) && cyc < 40) begin
      @(negedge clk);
      if (rvalid[0] === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b-spurious: rvalid with no outstanding request");
        end else begin
          er = exp_q.pop_front();
          if (rdata[0] !== er || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b-data resp%0d: rdata=%h err=%b, want %h 0", nresp, rdata[0], err[0], er);
          end
        end
        nresp++;
      end else begin
        run = 0;
      end
      if (i < 4) begin
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'(i * 4); f3[0] = 3'b010; wdata[0] = 32'd0;
      end else begin
        req[0] = 1'b0;
      end
      rdy = ready[0];
      @(posedge clk);
      if (i < 4 && rdy) begin
        model(0, 1'b0, addr[0], 3'b010, 32'd0, er, ee);
        exp_q.push_back(er);
        acc[i] = cyc;
        i++;
      end
      cyc++;
    end
    req[0] = 1'b0;
    checks++;
    if (nresp != 4 || i != 4) begin
      errors++;
      $display("FAIL b2b-count: accepts=%0d responses=%0d, want 4 4", i, nresp);
    end
    sp = B2B ? 1 : 2;
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (acc[k] - acc[k-1] != sp) begin
        errors++;
        $display("FAIL b2b-spacing acc%0d: %0d cycles, want %0d", k, acc[k] - acc[k-1], sp);
      end
    end
    exp_run = B2B ? 4 : 1;
    checks++;
    if (maxrun != exp_run) begin
      errors++;
      $display("FAIL b2b-rvalid-run: longest run %0d, want %0d", maxrun, exp_run);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
      addr[d] = 32'd0; f3[d] = 3'd0; wdata[d] = 32'd0;
    end
    test_reset();
    test_directed(0);
    test_directed(1);
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
